nav_drive_arbiter: RTL

Parametrised drive-command arbiter for the rover navigation system. It turns front and side-front ultrasonic distances, the manual-drive buttons and the speed-select switches into registered `DIR_STATE` and `PWM_STATE` codes for the Navigation motor block. Over the current fixed-threshold selector it adds:
- a state machine with timed back-off;
- a hysteresis re-check before resuming;
- obstacle debounce;
- a retry limit with a STUCK state.

It sits between the sensor/switch inputs and the Navigation block's `DIR_STATE`/`PWM_STATE` ports.

---
 rtl/nav_pkg.sv | 41 ++++
 rtl/nav_speed_map.sv | 33 +++
 rtl/nav_drive_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/nav_pkg.sv
// Shared codes for the rover navigation blocks: direction and speed codes
// driven to the Navigation motor block, plus the arbiter state encoding.
package nav_pkg;

    typedef enum logic [2:0] {
        ST_CHECK   = 3'd0,
        ST_CRUISE  = 3'd1,
        ST_BACKOFF = 3'd2,
        ST_STUCK   = 3'd3,
        ST_MANUAL  = 3'd4
    } nav_state_t;

    localparam logic [4:0] NEUTRAL       = 5'd0;
    localparam logic [4:0] FORWARD       = 5'd1;
    localparam logic [4:0] REVERSE       = 5'd2;
    localparam logic [4:0] FORWARD_RIGHT = 5'd3;
    localparam logic [4:0] BACK_RIGHT    = 5'd4;
    localparam logic [4:0] FORWARD_LEFT  = 5'd5;
    localparam logic [4:0] BACK_LEFT     = 5'd6;
    localparam logic [4:0] R_360         = 5'd7;
    localparam logic [4:0] L_360         = 5'd8;

    // Speed codes rise monotonically with duty so a cap is a plain compare.
    localparam logic [4:0] BOTH_17 = 5'd3;
    localparam logic [4:0] BOTH_25 = 5'd4;
    localparam logic [4:0] BOTH_38 = 5'd5;
    localparam logic [4:0] BOTH_50 = 5'd6;
    localparam logic [4:0] BOTH_62 = 5'd7;
    localparam logic [4:0] BOTH_75 = 5'd8;

    function automatic logic [4:0] man_dir(input logic [3:0] btn);
        case (btn)
            4'b0001: man_dir = FORWARD_RIGHT;
            4'b0010: man_dir = REVERSE;
            4'b0100: man_dir = FORWARD;
            4'b1000: man_dir = FORWARD_LEFT;
            default: man_dir = NEUTRAL;
        endcase
    endfunction

endpackage

// File: rtl/nav_speed_map.sv
// Registered one-hot speed switch to PWM code lookup, with an optional cap
// at BOTH_25 used while backing away from an obstacle.
module nav_speed_map
    import nav_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] speed_sel,
    input  logic       cap,
    output logic [4:0] pwm_state
);

    logic [4:0] sel_code;
    logic [4:0] capped;

    always_comb begin
        case (speed_sel)
            5'd1:    sel_code = BOTH_25;
            5'd2:    sel_code = BOTH_38;
            5'd4:    sel_code = BOTH_50;
            5'd8:    sel_code = BOTH_62;
            5'd16:   sel_code = BOTH_75;
            default: sel_code = BOTH_17;
        endcase
        capped = (cap && (sel_code > BOTH_25)) ? BOTH_25 : sel_code;
    end

    always_ff @(posedge clk) begin
        if (rst) pwm_state <= BOTH_17;
        else     pwm_state <= capped;
    end

endmodule

// File: rtl/nav_drive_arbiter.sv
// Drive-command arbiter: debounced obstacle detection, timed back-off with
// retry limit, hysteresis re-check and manual override.
module nav_drive_arbiter
    import nav_pkg::*;
#(
    parameter int DIST_W         = 8,
    parameter int STOP_DIST      = 25,
    parameter int CLEAR_DIST     = 35,
    parameter int OBST_HITS      = 2,
    parameter int BACKOFF_CYCLES = 50_000_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DIST_W-1:0] DIST_FRONT,
    input  logic [DIST_W-1:0] DIST_SIDE_FRONT,
    input  logic              DIST_VALID,
    input  logic              MANUAL,
    input  logic [3:0]        MAN_BTN,
    input  logic [4:0]        SPEED_SEL,
    output logic [4:0]        DIR_STATE,
    output logic [4:0]        PWM_STATE,
    output logic [2:0]        NAV_STATE,
    output logic              OBSTACLE
);

    localparam int TW = $clog2(BACKOFF_CYCLES + 1);
    localparam int HW = $clog2(OBST_HITS + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0]     TIMER_LOAD = TW'(BACKOFF_CYCLES - 1);
    localparam logic [HW-1:0]     HIT_LAST   = HW'(OBST_HITS - 1);
    localparam logic [RW-1:0]     RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [DIST_W-1:0] STOP_V     = DIST_W'(STOP_DIST);
    localparam logic [DIST_W-1:0] CLEAR_V    = DIST_W'(CLEAR_DIST);

    nav_state_t    state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [HW-1:0] hit_cnt, hit_next;
    logic [RW-1:0] retry_cnt, retry_next;
    logic [4:0]    dir_next;
    logic          is_obst, is_clear, enter_backoff;

    assign is_obst  = (DIST_FRONT <= STOP_V) || (DIST_SIDE_FRONT <= STOP_V);
    assign is_clear = (DIST_FRONT > CLEAR_V) && (DIST_SIDE_FRONT > CLEAR_V);
    assign NAV_STATE = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_CHECK;
            timer     <= '0;
            hit_cnt   <= '0;
            retry_cnt <= '0;
            DIR_STATE <= NEUTRAL;
            OBSTACLE  <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            hit_cnt   <= hit_next;
            retry_cnt <= retry_next;
            DIR_STATE <= dir_next;
            if (DIST_VALID) OBSTACLE <= is_obst;
        end
    end

    always_comb begin
        state_next    = state;
        timer_next    = timer;
        hit_next      = hit_cnt;
        retry_next    = retry_cnt;
        dir_next      = DIR_STATE;
        enter_backoff = 1'b0;

        if (MANUAL) begin
            state_next = ST_MANUAL;
        end else begin
            case (state)
                ST_CHECK: if (DIST_VALID) begin
                    if (is_clear) state_next    = ST_CRUISE;
                    else          enter_backoff = 1'b1;
                end
                ST_CRUISE: if (DIST_VALID) begin
                    if (!is_obst)                 hit_next      = '0;
                    else if (hit_cnt >= HIT_LAST) enter_backoff = 1'b1;
                    else                          hit_next      = hit_cnt + HW'(1);
                end
                ST_BACKOFF: begin
                    if (timer == '0)
                        state_next = (retry_cnt < RETRY_MAX) ? ST_CHECK : ST_STUCK;
                    else
                        timer_next = timer - TW'(1);
                end
                ST_STUCK:  state_next = ST_STUCK;
                ST_MANUAL: state_next = ST_CHECK;
                default:   state_next = ST_CHECK;
            endcase
        end

        if (enter_backoff) begin
            state_next = ST_BACKOFF;
            timer_next = TIMER_LOAD;
            if (retry_cnt != '1) retry_next = retry_cnt + RW'(1);
        end

        if (state_next != ST_CRUISE) hit_next = '0;
        if ((state_next == ST_MANUAL) || (state_next == ST_CRUISE && state != ST_CRUISE))
            retry_next = '0;

        // Back-off direction steers away from the side sensor that fired.
        case (state_next)
            ST_CRUISE:  dir_next = FORWARD;
            ST_MANUAL:  dir_next = man_dir(MAN_BTN);
            ST_BACKOFF: if (enter_backoff)
                dir_next = (DIST_SIDE_FRONT <= STOP_V) ? BACK_RIGHT : BACK_LEFT;
            default:    dir_next = NEUTRAL;
        endcase
    end

    nav_speed_map u_speed_map (
        .clk       (CLK),
        .rst       (RST),
        .speed_sel (SPEED_SEL),
        .cap       (state_next == ST_BACKOFF),
        .pwm_state (PWM_STATE)
    );

endmodule
